// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding selects, load-use and multi-cycle stalls, flushes, stall counter.
// All control outputs are combinational; only the mul/div FSM, its countdown and the stall counter are registered.
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_x,
  input  logic [REG_AW-1:0] rs2_x,
  input  logic [REG_AW-1:0] rd_x,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rs2_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              dmem_write_d,
  input  logic              dmem_write_m,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_x,
  input  logic [1:0]        result_src_x,
  input  logic [1:0]        result_src_w,
  input  logic              mc_start_x,
  input  logic              flush_all,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_x,
  output logic              flush_d,
  output logic              flush_x,
  output logic              flush_m,
  output logic              forward_m,
  output logic [1:0]        forward_a_x,
  output logic [1:0]        forward_b_x,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  localparam logic [5:0] LP_LOAD = (MC_LATENCY > 2) ? 6'(MC_LATENCY - 3) : 6'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [5:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lw_stall;
  logic             w_mc_stall;
  logic             w_unused_rsx;

  assign w_unused_rsx = result_src_x[1];

  assign forward_a_x = ((rs1_x != '0) && reg_write_m && (rs1_x == rd_m)) ? 2'b10 :
                       ((rs1_x != '0) && reg_write_w && (rs1_x == rd_w)) ? 2'b01 : 2'b00;
  assign forward_b_x = ((rs2_x != '0) && reg_write_m && (rs2_x == rd_m)) ? 2'b10 :
                       ((rs2_x != '0) && reg_write_w && (rs2_x == rd_w)) ? 2'b01 : 2'b00;

  assign forward_m = dmem_write_m && reg_write_w && (result_src_w == 2'b01) &&
                     (rd_w != '0) && (rs2_m == rd_w);

  assign w_lw_stall = result_src_x[0] && (rd_x != '0) && !dmem_write_d &&
                      ((rs1_d == rd_x) || (rs2_d == rd_x));

  // Reset masks the stall so nothing freezes while the pipeline is being reset.
  assign w_mc_stall = !rst && (((r_state == S_IDLE) && mc_start_x) || (r_state == S_BUSY));

  assign mc_busy = w_mc_stall;
  assign mc_done = !rst && (r_state == S_RELEASE);
  assign stall_f = (w_lw_stall || w_mc_stall) && !flush_all;
  assign stall_d = stall_f;
  assign stall_x = w_mc_stall && !flush_all;
  assign flush_m = w_mc_stall || flush_all;
  assign flush_d = pc_src_x || flush_all;
  assign flush_x = ((w_lw_stall || pc_src_x) && !w_mc_stall) || flush_all;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mc_start_x) begin
          if (MC_LATENCY == 2) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = LP_LOAD;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 6'd0) w_state_nxt = S_RELEASE;
        else               w_cnt_nxt   = r_cnt - 6'd1;
      end
      // The op is leaving X; a still-high mc_start_x belongs to it and is ignored.
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (flush_all) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 6'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (stall_f && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three parameterisations driven in lockstep against an op-age reference model.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rs2_m, rd_w;
  logic       dmem_write_d, dmem_write_m, reg_write_m, reg_write_w, pc_src_x;
  logic [1:0] result_src_x, result_src_w;
  logic       mc_start_x, flush_all;

  logic [2:0]  stall_f, stall_d, stall_x, flush_d, flush_x, flush_m, forward_m, mc_busy, mc_done;
  logic [5:0]  fa, fb;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: age of the op currently in X (-1 = none), and the saturating stall counters.
  int m_pos[3];
  int m_sc[3];
  int lat[3]  = '{4, 2, 3};
  int cmax[3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .rd_m(rd_m), .rs2_m(rs2_m), .rd_w(rd_w), .dmem_write_d(dmem_write_d),
    .dmem_write_m(dmem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_x(pc_src_x), .result_src_x(result_src_x), .result_src_w(result_src_w),
    .mc_start_x(mc_start_x), .flush_all(flush_all), .stall_f(stall_f[0]), .stall_d(stall_d[0]),
    .stall_x(stall_x[0]), .flush_d(flush_d[0]), .flush_x(flush_x[0]), .flush_m(flush_m[0]),
    .forward_m(forward_m[0]), .forward_a_x(fa[1:0]), .forward_b_x(fb[1:0]),
    .mc_busy(mc_busy[0]), .mc_done(mc_done[0]), .stall_cnt(sc0));

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(2), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .rd_m(rd_m), .rs2_m(rs2_m), .rd_w(rd_w), .dmem_write_d(dmem_write_d),
    .dmem_write_m(dmem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_x(pc_src_x), .result_src_x(result_src_x), .result_src_w(result_src_w),
    .mc_start_x(mc_start_x), .flush_all(flush_all), .stall_f(stall_f[1]), .stall_d(stall_d[1]),
    .stall_x(stall_x[1]), .flush_d(flush_d[1]), .flush_x(flush_x[1]), .flush_m(flush_m[1]),
    .forward_m(forward_m[1]), .forward_a_x(fa[3:2]), .forward_b_x(fb[3:2]),
    .mc_busy(mc_busy[1]), .mc_done(mc_done[1]), .stall_cnt(sc1));

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(3), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .rd_m(rd_m), .rs2_m(rs2_m), .rd_w(rd_w), .dmem_write_d(dmem_write_d),
    .dmem_write_m(dmem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_x(pc_src_x), .result_src_x(result_src_x), .result_src_w(result_src_w),
    .mc_start_x(mc_start_x), .flush_all(flush_all), .stall_f(stall_f[2]), .stall_d(stall_d[2]),
    .stall_x(stall_x[2]), .flush_d(flush_d[2]), .flush_x(flush_x[2]), .flush_m(flush_m[2]),
    .forward_m(forward_m[2]), .forward_a_x(fa[5:4]), .forward_b_x(fb[5:4]),
    .mc_busy(mc_busy[2]), .mc_done(mc_done[2]), .stall_cnt(sc2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lw();
    return result_src_x[0] && (rd_x != 0) && !dmem_write_d && ((rs1_d == rd_x) || (rs2_d == rd_x));
  endfunction

  function automatic bit mcs(input int k);
    if (rst) return 1'b0;
    if (m_pos[k] >= 0) return m_pos[k] < lat[k] - 1;
    return mc_start_x;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
    if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] get_sc(input int k);
    if (k == 0) return sc0;
    if (k == 1) return sc1;
    return {12'd0, sc2};
  endfunction

  function automatic bit exp_sf(input int k);
    return (lw() || mcs(k)) && !flush_all;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit ms;
      ms = mcs(k);
      chk($sformatf("stall_f[%0d]", k), 16'(stall_f[k]), 16'(exp_sf(k)));
      chk($sformatf("stall_d[%0d]", k), 16'(stall_d[k]), 16'(exp_sf(k)));
      chk($sformatf("stall_x[%0d]", k), 16'(stall_x[k]), 16'(ms && !flush_all));
      chk($sformatf("flush_d[%0d]", k), 16'(flush_d[k]), 16'(pc_src_x || flush_all));
      chk($sformatf("flush_x[%0d]", k), 16'(flush_x[k]), 16'(((lw() || pc_src_x) && !ms) || flush_all));
      chk($sformatf("flush_m[%0d]", k), 16'(flush_m[k]), 16'(ms || flush_all));
      chk($sformatf("mc_busy[%0d]", k), 16'(mc_busy[k]), 16'(ms));
      chk($sformatf("mc_done[%0d]", k), 16'(mc_done[k]), 16'(!rst && m_pos[k] == lat[k] - 1));
      chk($sformatf("forward_m[%0d]", k), 16'(forward_m[k]),
          16'(dmem_write_m && reg_write_w && result_src_w == 2'b01 && rd_w != 0 && rs2_m == rd_w));
      chk($sformatf("fwd_a[%0d]", k), 16'(fa[2*k +: 2]), 16'(fwd(rs1_x)));
      chk($sformatf("fwd_b[%0d]", k), 16'(fb[2*k +: 2]), 16'(fwd(rs2_x)));
      chk($sformatf("stall_cnt[%0d]", k), get_sc(k), 16'(m_sc[k]));
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_pos[k] = -1;
        m_sc[k]  = 0;
      end else begin
        if (exp_sf(k) && m_sc[k] < cmax[k]) m_sc[k]++;
        if (flush_all)           m_pos[k] = -1;
        else if (m_pos[k] >= 0)  m_pos[k] = (m_pos[k] + 1 == lat[k]) ? -1 : m_pos[k] + 1;
        else if (mc_start_x)     m_pos[k] = 1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_in();
    {rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rs2_m, rd_w} = '0;
    {dmem_write_d, dmem_write_m, reg_write_m, reg_write_w, pc_src_x} = '0;
    result_src_x = 2'b00; result_src_w = 2'b00;
    mc_start_x = 1'b0; flush_all = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_pos[k] = -1; m_sc[k] = 0; end
    idle_in();
    // Reset, with a multi-cycle request that must be masked.
    rst = 1'b1; mc_start_x = 1'b1;
    settle(); chk("rst_busy", 16'(mc_busy[0]), 16'd0); chk("rst_stall_x", 16'(stall_x[0]), 16'd0); adv();
    settle(); adv();
    rst = 1'b0; mc_start_x = 1'b0;
    settle(); chk("rst_cnt", sc0, 16'd0); adv();

    // Forwarding priority and x0.
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_x = 5;
    settle(); chk("c1_fwd_m", 16'(fa[1:0]), 16'd2); adv();
    rs1_x = 0;
    settle(); chk("c1_fwd_x0", 16'(fa[1:0]), 16'd0); adv();

    // Load-use stall and the rd_x==0 exemption.
    idle_in(); result_src_x = 2'b01; rd_x = 7; rs2_d = 7;
    settle(); chk("c2_stall_f", 16'(stall_f[0]), 16'd1); chk("c2_flush_x", 16'(flush_x[0]), 16'd1); adv();
    idle_in();
    settle(); chk("c2_cnt", sc0, 16'd1); adv();
    result_src_x = 2'b01; rd_x = 0; rs2_d = 0;
    settle(); chk("c2_rd0", 16'(stall_f[0]), 16'd0); adv();

    // MC_LATENCY=4 op with mc_start_x held.
    idle_in(); mc_start_x = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("c3_stall_x%0d", c), 16'(stall_x[0]), 16'(c < 3));
      chk($sformatf("c3_done%0d", c), 16'(mc_done[0]), 16'(c == 3));
      adv();
    end
    mc_start_x = 1'b0;
    settle(); chk("c3_idle", 16'(mc_busy[0] | mc_done[0]), 16'd0); adv();

    // MC_LATENCY=2 with a load-use in D: no flush_x while stalled.
    for (int c = 0; c < 3; c++) begin settle(); adv(); end
    mc_start_x = 1'b1; result_src_x = 2'b01; rd_x = 7; rs1_d = 7;
    settle(); chk("c4_stall", 16'(stall_x[1]), 16'd1); chk("c4_nofx", 16'(flush_x[1]), 16'd0); adv();
    settle(); chk("c4_done", 16'(mc_done[1]), 16'd1); chk("c4_unstall", 16'(stall_x[1]), 16'd0); adv();

    // flush_all during BUSY, then reset during BUSY.
    idle_in();
    for (int c = 0; c < 4; c++) begin settle(); adv(); end
    mc_start_x = 1'b1;
    settle(); adv();
    flush_all = 1'b1;
    settle();
    chk("c5_fd", 16'(flush_d[0]), 16'd1); chk("c5_fx", 16'(flush_x[0]), 16'd1);
    chk("c5_fm", 16'(flush_m[0]), 16'd1); chk("c5_sx", 16'(stall_x[0]), 16'd0);
    adv();
    flush_all = 1'b0; mc_start_x = 1'b0;
    settle(); chk("c5_idle", 16'(mc_busy[0]), 16'd0); adv();
    mc_start_x = 1'b1;
    settle(); adv();
    rst = 1'b1;
    settle(); chk("c5_rst_busy", 16'(mc_busy[0]), 16'd0); adv();
    rst = 1'b0; mc_start_x = 1'b0;
    settle(); chk("c5_rst_idle", 16'(mc_busy[0] | mc_done[0]), 16'd0); adv();

    // 4-bit stall counter saturates.
    idle_in(); rst = 1'b1; settle(); adv(); rst = 1'b0;
    result_src_x = 2'b01; rd_x = 3; rs1_d = 3;
    for (int c = 0; c < 20; c++) begin settle(); adv(); end
    settle(); chk("c6_sat", {12'd0, sc2}, 16'd15); adv();
    settle(); chk("c6_hold", {12'd0, sc2}, 16'd15); adv();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_x = 5'($urandom_range(0, 3)); rs2_x = 5'($urandom_range(0, 3));
      rd_x  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rs2_m = 5'($urandom_range(0, 3)); rd_w  = 5'($urandom_range(0, 3));
      dmem_write_d = 1'($urandom); dmem_write_m = 1'($urandom);
      reg_write_m  = 1'($urandom); reg_write_w  = 1'($urandom);
      result_src_x = 2'($urandom); result_src_w = 2'($urandom);
      pc_src_x   = ($urandom_range(0, 4) == 0);
      mc_start_x = ($urandom_range(0, 2) == 0);
      flush_all  = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 39) == 0);
      settle(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter MC_LATENCY, default 4, meaning total X-stage cycles of a multi-cycle op; legal values are 2 to 64.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-005 SHALL have inputs rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rs2_m and rd_w, each REG_AW wide, carrying register addresses per stage.
REQ-006 SHALL have inputs dmem_write_d, dmem_write_m, reg_write_m, reg_write_w and pc_src_x, each 1 bit, carrying stage control.
REQ-007 SHALL have inputs result_src_x and result_src_w, each 2 bits; bit0 set means a load.
REQ-008 SHALL have input mc_start_x (1 bit): the X instruction is multi-cycle (mul/div) and is never a taken branch.
REQ-009 SHALL have input flush_all (1 bit): trap/redirect kill of D, X and M.
REQ-010 SHALL have 1-bit outputs stall_f, stall_d, stall_x, flush_d, flush_x, flush_m and forward_m.
REQ-011 SHALL have 2-bit outputs forward_a_x and forward_b_x, encoded 10 = from M, 01 = from W, 00 = register file.
REQ-012 SHALL have 1-bit outputs mc_busy and mc_done, plus output stall_cnt (CNT_W bits).

Function
REQ-013 forward_a_x SHALL be 10 if rs1_x!=0, reg_write_m and rs1_x==rd_m; else 01 if rs1_x!=0, reg_write_w and rs1_x==rd_w; else 00. forward_b_x SHALL follow the same rule using rs2_x.
REQ-014 forward_m SHALL be 1 only when dmem_write_m, reg_write_w, result_src_w==01, rd_w!=0 and rs2_m==rd_w all hold.
REQ-015 lw_stall SHALL be 1 only when result_src_x[0] is set, rd_x!=0, dmem_write_d is 0, and either rs1_d==rd_x or rs2_d==rd_x.
REQ-016 The FSM SHALL have states IDLE, BUSY and RELEASE; mc_stall SHALL be (IDLE and mc_start_x) or BUSY.
REQ-017 From IDLE with mc_start_x and no flush_all, the FSM SHALL go to RELEASE if MC_LATENCY==2; otherwise it SHALL go to BUSY and load cnt=MC_LATENCY-3.
REQ-018 In BUSY, if cnt==0 the FSM SHALL go to RELEASE, else decrement cnt. From RELEASE the FSM SHALL go to IDLE unconditionally.
REQ-019 In RELEASE, mc_start_x SHALL be ignored, so the same op is not restarted.
REQ-020 The X instruction SHALL occupy X for exactly MC_LATENCY cycles, with mc_stall high for MC_LATENCY-1 of them.
REQ-021 mc_busy SHALL equal mc_stall. mc_done SHALL be 1 exactly in RELEASE.
REQ-022 stall_f and stall_d SHALL equal (lw_stall or mc_stall) and not flush_all. stall_x SHALL equal mc_stall and not flush_all.
REQ-023 flush_m SHALL equal mc_stall or flush_all, so a bubble enters M.
REQ-024 flush_d SHALL equal pc_src_x or flush_all.
REQ-025 flush_x SHALL equal ((lw_stall or pc_src_x) and not mc_stall) or flush_all.
REQ-026 flush_all SHALL force the next state to IDLE from any state, overriding mc_start_x.
REQ-027 stall_cnt SHALL increment by 1 each cycle stall_f is 1 and SHALL saturate at all-ones without wrapping.
REQ-028 All forwarding, stall and flush outputs SHALL be combinational from inputs and state; only the FSM, cnt and stall_cnt SHALL be registered.

Reset
REQ-029 While rst is 1 at a clk edge, the FSM SHALL go to IDLE, cnt to 0 and stall_cnt to 0.
REQ-030 While rst is 1, mc_busy, mc_done and stall_x SHALL be 0 regardless of mc_start_x.
REQ-031 rst asserted mid-BUSY SHALL abort the op; the next cycle SHALL be IDLE with no stall.

Verification
REQ-032 Case 1: rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_x=5 -> forward_a_x=10. With rs1_x=0 -> forward_a_x=00.
REQ-033 Case 2: load in X with rd_x=7 and rs2_d=7 -> stall_f=stall_d=flush_x=1 for one cycle and stall_cnt becomes 1. The same case with rd_x=0 -> no stall.
REQ-034 Case 3: MC_LATENCY=4 with mc_start_x held -> stall_x high for cycles 0-2, mc_done=1 in cycle 3, IDLE in cycle 4.
REQ-035 Case 4: MC_LATENCY=2 -> one stall cycle, then RELEASE. With a load-use in D during the op -> flush_x=0 while stalled.
REQ-036 Case 5: flush_all during BUSY -> flush_d=flush_x=flush_m=1 and stall_x=0, then IDLE. rst during BUSY -> same idle result.
REQ-037 Case 6: CNT_W=4 with stall_f held for 20 cycles -> stall_cnt=15 and holds at 15.
